// File: rtl/frac_lutk_ccff_tile.sv
// Fracturable K-input LUT whose truth table and mode bit are loaded through a serial CCFF chain.
// Define FRAC_LUTK_CCFF_PARITY_EN to append an even-parity bit to the chain and expose cfg_err.
module frac_lutk_ccff_tile #(
  parameter int K = 6
) (
  input  logic         prog_clk,
  input  logic         pReset,
  input  logic         ccff_en,
  input  logic         ccff_head,
  output logic         ccff_tail,
  input  logic [K-1:0] lut_in,
  output logic [1:0]   lutk1_out,
  output logic         lutk_out,
`ifdef FRAC_LUTK_CCFF_PARITY_EN
  output logic         cfg_err,
`endif
  output logic         cfg_done
);

  localparam int S = 1 << K;
`ifdef FRAC_LUTK_CCFF_PARITY_EN
  localparam int N = S + 2;
`else
  localparam int N = S + 1;
`endif
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  logic [N-1:0]  chain_q, chain_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;
  logic          errFlag;

  // Chain shifts toward chain[N-1]; the counter saturates so reload/readback keeps done set.
  always_comb begin
    chain_d = chain_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    if (ccff_en) begin
      chain_d = {chain_q[N-2:0], ccff_head};
      if (cnt_q != CNT_FULL) begin
        cnt_d = cnt_q + 1'b1;
      end
      if (cnt_q == CNT_LAST) begin
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      chain_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      chain_q <= chain_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

`ifdef FRAC_LUTK_CCFF_PARITY_EN
  logic err_q, err_d;

  // Parity is judged once, on the shift that completes the first full load.
  always_comb begin
    err_d = err_q;
    if (ccff_en && (cnt_q == CNT_LAST)) begin
      err_d = ^chain_d;
    end
  end

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign errFlag = err_q;
  assign cfg_err = err_q;
`else
  assign errFlag = 1'b0;
`endif

  logic [S-1:0] sram;
  logic         mode;
  logic [K-2:0] idx;
  logic         outEnable;

  assign sram      = chain_q[S-1:0];
  assign mode      = chain_q[S];
  assign idx       = lut_in[K-2:0];
  assign outEnable = done_q & ~ccff_en & ~errFlag;

  // Lower half of the table feeds lutk1_out[0], upper half feeds lutk1_out[1].
  assign lutk1_out = outEnable ? {sram[{1'b1, idx}], sram[{1'b0, idx}]} : 2'b00;
  assign lutk_out  = outEnable & ~mode & sram[lut_in];
  assign ccff_tail = chain_q[N-1];
  assign cfg_done  = done_q;

endmodule
